lzc_norm: RTL and testbench
===========================

LZC_NORM -- requirements
Module: lzc_norm

Interface
REQ-001 The block SHALL have parameter WIDTH, default 128, meaning data width; legal values are powers of two, 16..128.
REQ-002 The block SHALL have parameter TAG_W, default 4, meaning the width of the sideband tag carried with each operand.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operand is presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the operand this cycle.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: the operand.
REQ-008 The block SHALL have port in_mode, input, 1 bit: 0 counts leading zeros, 1 counts leading ones.
REQ-009 The block SHALL have port in_tag, input, TAG_W bits: sideband data, passed through unchanged.
REQ-010 The block SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port out_data, output, WIDTH bits: the normalised operand.
REQ-013 The block SHALL have port out_cnt, output, CW = log2(WIDTH) bits: the leading-digit count.
REQ-014 The block SHALL have port out_zero, output, 1 bit: the operand consisted entirely of the counted digit.
REQ-015 The block SHALL have port out_tag, output, TAG_W bits: the tag of the result.

Function
REQ-016 An operand SHALL transfer on a cycle with in_valid and in_ready both high; a result SHALL transfer on a cycle with out_valid and out_ready both high.
REQ-017 The datapath SHALL have two register stages:
- S1 registers the count, the zero flag, the operand and the tag.
- S2 registers the shifted data, the count, the zero flag and the tag.
REQ-018 Latency SHALL be 2 cycles: an operand accepted at edge N is presented with out_valid at edge N+2 when there is no backpressure.
REQ-019 Throughput SHALL be one operand per cycle with out_ready held high.
REQ-020 Stall rules:
- adv2 = ~s2_valid | out_ready.
- adv1 = ~s1_valid | adv2.
- in_ready = adv1, purely combinational from state and out_ready, with no dependence on in_valid.
REQ-021 While out_valid is high and out_ready is low, out_data, out_cnt, out_zero and out_tag SHALL hold stable.
REQ-022 Results SHALL retire in acceptance order, with no drop or duplication under any out_ready pattern.
REQ-023 For mode 0, out_cnt SHALL equal the number of consecutive zeros counted from bit WIDTH-1 downwards; for mode 1 it counts consecutive ones.
REQ-024 out_data SHALL equal the operand shifted left by out_cnt, with zeros filled into the low bits, in both modes.
REQ-025 If the operand is all zeros (mode 0) or all ones (mode 1):
- out_zero = 1;
- out_cnt = 0;
- out_data = the operand unchanged.
Otherwise out_zero = 0.
REQ-026 An operand with a non-counted MSB SHALL give out_cnt = 0, out_zero = 0 and out_data = the operand.

Reset
REQ-027 While reset is high at a clock edge, both stage valid bits SHALL clear, discarding any in-flight operands.
REQ-028 The cycle after reset, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-029 Reset asserted mid-stall SHALL discard held results; an in_valid presented during reset SHALL NOT be accepted.
REQ-030 After reset, data registers SHALL read 0: out_data = 0, out_cnt = 0, out_zero = 0, out_tag = 0.

Structure
REQ-031 Shared package lzc_pkg SHALL hold:
- the CW derivation function;
- the mode encoding constants LZC_ZEROS = 0 and LZC_ONES = 1.
REQ-032 The count SHALL be computed by a single sub-module, lzc_tree #(WIDTH): a combinational recursive halving tree that outputs count and all-zero flag.
REQ-033 Mode 1 SHALL be realised by inverting the operand before lzc_tree; the shifter SHALL act on the original operand.

Verification
REQ-034 Scenario: WIDTH=128, mode 0, in_data=1<<100, out_ready=1 -> after 2 cycles out_cnt=27, out_data=1<<127, out_zero=0.
REQ-035 Scenario: mode 0, in_data=0 -> out_zero=1, out_cnt=0, out_data=0; mode 1, in_data=all ones -> out_zero=1, out_cnt=0, out_data=all ones.
REQ-036 Scenario: mode 1, in_data=0xFF00...00 (top 8 bits set) -> out_cnt=8, out_data=0; mode 1, in_data=0x7F...F -> out_cnt=0, out_zero=0.
REQ-037 Scenario: 10 back-to-back operands with tags 0..9 and out_ready=1 -> 10 results on consecutive cycles, tags 0..9 in order.
REQ-038 Scenario: out_ready=0 for 5 cycles with a continuous stream -> in_ready falls after 2 accepts, outputs stay stable, and all results retire in order on release.
REQ-039 Scenario: reset pulse while both stages are full -> next cycle out_valid=0, in_ready=1, and no stale result ever appears.

Source files
------------

// File: rtl/lzc_pkg.sv
// Shared definitions for the leading-digit count / normalise block.
// Holds the mode encoding and the count-width derivation.
package lzc_pkg;

  localparam logic LZC_ZEROS = 1'b0;
  localparam logic LZC_ONES  = 1'b1;

  function automatic int lzc_cw(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/lzc_tree.sv
// Combinational leading-zero counter built as a recursive halving tree.
// cnt is only meaningful when zero is low.
module lzc_tree
  import lzc_pkg::*;
#(
  parameter  int WIDTH = 128,
  localparam int CW    = lzc_cw(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CW-1:0]    cnt,
  output logic             zero
);

  generate
    if (WIDTH == 2) begin : g_leaf
      assign cnt  = ~data[1];
      assign zero = ~(data[1] | data[0]);
    end else begin : g_node
      localparam int HW = WIDTH / 2;

      logic [CW-2:0] cnt_hi;
      logic [CW-2:0] cnt_lo;
      logic          zero_hi;
      logic          zero_lo;

      lzc_tree #(.WIDTH(HW)) u_hi (
        .data (data[WIDTH-1:HW]),
        .cnt  (cnt_hi),
        .zero (zero_hi)
      );

      lzc_tree #(.WIDTH(HW)) u_lo (
        .data (data[HW-1:0]),
        .cnt  (cnt_lo),
        .zero (zero_lo)
      );

      // An empty upper half contributes HW zeros, then the lower half continues the run.
      assign zero = zero_hi & zero_lo;
      assign cnt  = zero_hi ? {1'b1, cnt_lo} : {1'b0, cnt_hi};
    end
  endgenerate

endmodule

// File: rtl/lzc_norm.sv
// Two-stage leading-digit count and left-normalise with valid/ready handshake.
// Mode 1 counts leading ones by inverting the operand ahead of the counter.
module lzc_norm
  import lzc_pkg::*;
#(
  parameter  int WIDTH = 128,
  parameter  int TAG_W = 4,
  localparam int CW    = lzc_cw(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_cnt,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  logic [WIDTH-1:0] scan_p0;
  logic [CW-1:0]    cnt_p0;
  logic             zero_p0;

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic [CW-1:0]    cnt_p1;
  logic             zero_p1;
  logic [TAG_W-1:0] tag_p1;

  logic             vld_p2;
  logic [WIDTH-1:0] data_p2;
  logic [CW-1:0]    cnt_p2;
  logic             zero_p2;
  logic [TAG_W-1:0] tag_p2;

  logic             adv1;
  logic             adv2;

  assign adv2     = ~vld_p2 | out_ready;
  assign adv1     = ~vld_p1 | adv2;
  assign in_ready = adv1;

  assign scan_p0 = (in_mode == LZC_ONES) ? ~in_data : in_data;

  lzc_tree #(.WIDTH(WIDTH)) u_tree (
    .data (scan_p0),
    .cnt  (cnt_p0),
    .zero (zero_p0)
  );

  // Stage 1: count, uniform-operand flag, raw operand and tag
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      cnt_p1  <= '0;
      zero_p1 <= 1'b0;
      tag_p1  <= '0;
    end else if (adv1) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        data_p1 <= in_data;
        cnt_p1  <= zero_p0 ? '0 : cnt_p0;
        zero_p1 <= zero_p0;
        tag_p1  <= in_tag;
      end
    end
  end

  // Stage 2: normalised operand; a forced zero count leaves uniform operands untouched
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      cnt_p2  <= '0;
      zero_p2 <= 1'b0;
      tag_p2  <= '0;
    end else if (adv2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= data_p1 << cnt_p1;
        cnt_p2  <= cnt_p1;
        zero_p2 <= zero_p1;
        tag_p2  <= tag_p1;
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_data  = data_p2;
  assign out_cnt   = cnt_p2;
  assign out_zero  = zero_p2;
  assign out_tag   = tag_p2;

endmodule

// File: tb/tb_lzc_norm.sv
// Directed bench for lzc_norm: reference results from a bit-scan model,
// checked against the DUT every cycle a result is presented.
module tb_lzc_norm;
  import lzc_pkg::*;

  localparam int W  = 128;
  localparam int TW = 4;
  localparam int CW = 7;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_mode;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_cnt;
  logic          out_zero;
  logic [TW-1:0] out_tag;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0]  data;
    logic [CW-1:0] cnt;
    logic          zero;
    logic [TW-1:0] tag;
  } res_t;

  typedef struct {
    logic [W-1:0]  data;
    logic          mode;
    logic [CW-1:0] cnt;
    logic          zero;
    logic [W-1:0]  odata;
  } vec_t;

  res_t q[$];
  vec_t vt[9];

  lzc_norm #(.WIDTH(W), .TAG_W(TW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .out_zero  (out_zero),
    .out_tag   (out_tag)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit 100000 reached, required finish before it");
    $fatal(1, "watchdog expired");
  end

  function automatic res_t model(input logic [W-1:0] d, input logic m, input logic [TW-1:0] t);
    res_t r;
    int   c = 0;
    for (int i = W - 1; i >= 0; i--)
      if (d[i] == m && c == W - 1 - i) c++;
    r.tag = t;
    if (c == W) begin
      r.zero = 1'b1;
      r.cnt  = '0;
      r.data = d;
    end else begin
      r.zero = 1'b0;
      r.cnt  = CW'(c);
      r.data = d << c;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic m, input logic [TW-1:0] t);
    int b = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_tag   = t;
    while (!in_ready && b < 50) begin
      step();
      b++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", b);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_idle(input string p);
    chk({p, "_out_valid"}, W'(out_valid), W'(0));
    chk({p, "_in_ready"},  W'(in_ready),  W'(1));
    chk({p, "_out_data"},  out_data,      W'(0));
    chk({p, "_out_cnt"},   W'(out_cnt),   W'(0));
    chk({p, "_out_zero"},  W'(out_zero),  W'(0));
    chk({p, "_out_tag"},   W'(out_tag),   W'(0));
  endtask

  task automatic drain();
    int b = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while ((q.size() != 0 || out_valid) && b < 20) begin
      step();
      b++;
    end
    chk("drain_queue_empty", W'(q.size()), W'(0));
  endtask

  // Scoreboard: check presented results against the model, hold during stalls
  logic stall_q = 1'b0;
  res_t prev;
  always @(negedge clock) begin
    if (reset) begin
      q.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_data", out_data,       prev.data);
        chk("hold_cnt",  W'(out_cnt),    W'(prev.cnt));
        chk("hold_zero", W'(out_zero),   W'(prev.zero));
        chk("hold_tag",  W'(out_tag),    W'(prev.tag));
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_result: got tag %0d, expected no result", out_tag);
        end else begin
          chk("res_data", out_data,     q[0].data);
          chk("res_cnt",  W'(out_cnt),  W'(q[0].cnt));
          chk("res_zero", W'(out_zero), W'(q[0].zero));
          chk("res_tag",  W'(out_tag),  W'(q[0].tag));
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_data, in_mode, in_tag));
      stall_q   = out_valid && !out_ready;
      prev.data = out_data;
      prev.cnt  = out_cnt;
      prev.zero = out_zero;
      prev.tag  = out_tag;
    end
  end

  initial begin
    res_t r;
    int   b;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = LZC_ZEROS;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk_idle("after_reset");

    vt[0] = '{data: W'(1) << 100, mode: 1'b0, cnt: 7'd27, zero: 1'b0, odata: W'(1) << 127};
    vt[1] = '{data: '0, mode: 1'b0, cnt: 7'd0, zero: 1'b1, odata: '0};
    vt[2] = '{data: '1, mode: 1'b1, cnt: 7'd0, zero: 1'b1, odata: '1};
    vt[3] = '{data: {8'hFF, 120'h0}, mode: 1'b1, cnt: 7'd8, zero: 1'b0, odata: '0};
    vt[4] = '{data: {1'b0, {127{1'b1}}}, mode: 1'b1, cnt: 7'd0, zero: 1'b0, odata: {1'b0, {127{1'b1}}}};
    vt[5] = '{data: W'(1), mode: 1'b0, cnt: 7'd127, zero: 1'b0, odata: W'(1) << 127};
    vt[6] = '{data: {1'b1, 127'h0}, mode: 1'b0, cnt: 7'd0, zero: 1'b0, odata: {1'b1, 127'h0}};
    vt[7] = '{data: {4'hE, 124'h5}, mode: 1'b1, cnt: 7'd3, zero: 1'b0, odata: {1'b0, 124'h5, 3'b000}};
    vt[8] = '{data: {8'h00, 8'h3C, 112'h0}, mode: 1'b0, cnt: 7'd10, zero: 1'b0, odata: {8'hF0, 120'h0}};

    // Pin the model to hand-computed results
    foreach (vt[i]) begin
      r = model(vt[i].data, vt[i].mode, TW'(i));
      chk($sformatf("model_cnt_%0d", i),  W'(r.cnt),  W'(vt[i].cnt));
      chk($sformatf("model_zero_%0d", i), W'(r.zero), W'(vt[i].zero));
      chk($sformatf("model_data_%0d", i), r.data,     vt[i].odata);
    end

    // Two-cycle latency on an isolated operand
    send(vt[0].data, vt[0].mode, 4'd5);
    chk("lat_not_yet_valid", W'(out_valid), W'(0));
    step();
    chk("lat_valid",    W'(out_valid), W'(1));
    chk("lat_cnt_27",   W'(out_cnt),   W'(27));
    chk("lat_data_127", out_data,      W'(1) << 127);
    chk("lat_zero",     W'(out_zero),  W'(0));
    drain();

    foreach (vt[i]) send(vt[i].data, vt[i].mode, TW'(i));
    drain();

    // Ten back-to-back operands retire on consecutive cycles in order
    fork
      begin
        for (int i = 0; i < 10; i++) send(vt[i % 9].data, vt[i % 9].mode, TW'(i));
      end
      begin
        b = 0;
        while (!out_valid && b < 10) begin
          step();
          b++;
        end
        for (int j = 0; j < 10; j++) begin
          chk($sformatf("b2b_valid_%0d", j), W'(out_valid), W'(1));
          chk($sformatf("b2b_tag_%0d", j),   W'(out_tag),   W'(j));
          step();
        end
      end
    join
    drain();

    // Backpressure: two accepts fill the pipe, then input stalls
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = vt[3].data;
    in_mode   = vt[3].mode;
    in_tag    = 4'd10;
    chk("bp_ready_0", W'(in_ready), W'(1));
    step();
    in_data = vt[5].data;
    in_mode = vt[5].mode;
    in_tag  = 4'd11;
    chk("bp_ready_1", W'(in_ready), W'(1));
    step();
    in_data = vt[7].data;
    in_mode = vt[7].mode;
    in_tag  = 4'd12;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_stalled_ready_%0d", k), W'(in_ready),  W'(0));
      chk($sformatf("bp_stalled_tag_%0d", k),   W'(out_tag),   W'(10));
      step();
    end
    out_ready = 1'b1;
    send(vt[7].data, vt[7].mode, 4'd12);
    send(vt[8].data, vt[8].mode, 4'd13);
    send(vt[2].data, vt[2].mode, 4'd14);
    drain();

    // Reset with both stages full discards everything in flight
    out_ready = 1'b0;
    send(vt[3].data, vt[3].mode, 4'd1);
    send(vt[8].data, vt[8].mode, 4'd2);
    chk("full_valid", W'(out_valid), W'(1));
    chk("full_ready", W'(in_ready),  W'(0));
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = vt[6].data;
    in_tag   = 4'd3;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    chk_idle("mid_stall_reset");
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("no_stale_%0d", k), W'(out_valid), W'(0));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
